// File: rtl/core_bus_mem_responder.sv
// Burst-capable memory responder: 32-bit word storage behind a read/write command bus with
// one-cycle read latency, per-beat decode/slave-error classification and byte-lane writes.
module core_bus_mem_responder #(
    parameter logic [33:0] BASE_ADDR   = 34'h0,
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter logic [33:0] ERR_BASE    = 34'h1000,
    parameter int unsigned ERR_WORDS   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [33:0] m_address,
    input  logic [4:0]  m_burstcount,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [31:0] m_writedata,
    input  logic [3:0]  m_byteenable,
    output logic        m_waitrequest,
    output logic [31:0] m_readdata,
    output logic        m_readdatavalid,
    output logic [1:0]  m_response
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BASE_W  = BASE_ADDR[33:2];
    localparam logic [31:0] ERR_W   = ERR_BASE[33:2];
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    localparam logic [31:0] ERR_U   = 32'(ERR_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  left_q, left_d;

    logic [31:0] cmd_word;
    logic [4:0]  cmd_len;
    logic        wr_en;
    logic        wr_ok;
    logic [31:0] wr_word;
    resp_e       rd_resp;
    logic [1:0]  unused_addr_lsb;

    // Offsets wrap modulo 2^32, so one unsigned compare covers both window edges.
    function automatic resp_e classify(input logic [31:0] w);
        if ((w - BASE_W) >= DEPTH_U) return RESP_DECERR;
        if ((w - ERR_W) < ERR_U)     return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] mem_idx(input logic [31:0] w);
        return IDX_W'(w - BASE_W);
    endfunction

    assign unused_addr_lsb = m_address[1:0];
    assign cmd_word        = m_address[33:2];
    assign cmd_len         = (m_burstcount == 5'd0) ? 5'd1 : m_burstcount;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        wr_en   = 1'b0;
        wr_word = addr_q;
        case (state_q)
            IDLE: begin
                if (m_read) begin
                    addr_d  = cmd_word;
                    left_d  = cmd_len;
                    state_d = READ;
                end else if (m_write) begin
                    wr_en   = 1'b1;
                    wr_word = cmd_word;
                    addr_d  = cmd_word + 32'd1;
                    left_d  = cmd_len - 5'd1;
                    if (cmd_len != 5'd1) state_d = WRITE;
                end
            end
            READ: begin
                addr_d = addr_q + 32'd1;
                left_d = left_q - 5'd1;
                if (left_q == 5'd1) state_d = IDLE;
            end
            WRITE: begin
                if (m_write) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + 32'd1;
                    left_d = left_q - 5'd1;
                    if (left_q == 5'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
        end
    end

    assign wr_ok = wr_en && (classify(wr_word) == RESP_OKAY);

    // NOTE: storage has no reset; contents must survive rst_n and a RAM cannot be cleared in one edge.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (m_byteenable[b]) mem[mem_idx(wr_word)][8*b +: 8] <= m_writedata[8*b +: 8];
            end
        end
    end

    // Read beats come straight from the beat address register, giving one-cycle latency.
    always_comb begin
        rd_resp         = classify(addr_q);
        m_waitrequest   = (state_q == READ);
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        m_response      = RESP_OKAY;
        if (state_q == READ) begin
            m_readdatavalid = 1'b1;
            m_response      = rd_resp;
            m_readdata      = (rd_resp == RESP_DECERR) ? 32'd0 : mem[mem_idx(addr_q)];
        end
    end

endmodule

// File: tb/tb_core_bus_mem_responder.sv
// Self-checking bench: two responders (no error window / one-word error window at 0x1000)
// share stimulus and are compared against a word-array reference model.
module tb_core_bus_mem_responder;

    localparam longint unsigned BASE_B  = 64'h0;
    localparam longint unsigned DEPTH   = 8192;
    localparam longint unsigned ERR_B   = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] m_address;
    logic [4:0]  m_burstcount;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [1:0]  waitreq;
    logic [1:0]  rvalid;
    logic [31:0] rdata [2];
    logic [1:0]  resp  [2];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mdl_mem   [2][8192];
    bit          mdl_known [2][8192];
    logic [31:0] wd  [32];
    logic [3:0]  wbe [32];

    always #5 clk = ~clk;

    core_bus_mem_responder #(
        .BASE_ADDR(34'h0), .DEPTH_WORDS(8192), .ERR_BASE(34'h1000), .ERR_WORDS(0)
    ) dut_plain (
        .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(waitreq[0]), .m_readdata(rdata[0]),
        .m_readdatavalid(rvalid[0]), .m_response(resp[0])
    );

    core_bus_mem_responder #(
        .BASE_ADDR(34'h0), .DEPTH_WORDS(8192), .ERR_BASE(34'h1000), .ERR_WORDS(1)
    ) dut_err (
        .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(waitreq[1]), .m_readdata(rdata[1]),
        .m_readdatavalid(rvalid[1]), .m_response(resp[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Byte-address range test; instance 1 has a one-word error window at 0x1000.
    function automatic logic [1:0] mdl_class(input int d, input logic [31:0] w);
        longint unsigned b  = 64'(w) << 2;
        longint unsigned ew = (d == 1) ? 64'd1 : 64'd0;
        if (b < BASE_B || b >= BASE_B + 4 * DEPTH) return 2'b11;
        if (b >= ERR_B && b < ERR_B + 4 * ew)      return 2'b10;
        return 2'b00;
    endfunction

    function automatic int mdl_idx(input logic [31:0] w);
        return int'(((64'(w) << 2) - BASE_B) >> 2);
    endfunction

    task automatic mdl_write(input logic [31:0] w, input logic [31:0] data, input logic [3:0] be);
        for (int d = 0; d < 2; d++) begin
            if (mdl_class(d, w) == 2'b00) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl_mem[d][mdl_idx(w)][8*b +: 8] = data[8*b +: 8];
                if (be == 4'hF) mdl_known[d][mdl_idx(w)] = 1'b1;
            end
        end
    endtask

    task automatic check_idle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("idle%0d_valid", d), 64'(rvalid[d]), 64'd0);
            check($sformatf("idle%0d_wait", d), 64'(waitreq[d]), 64'd0);
            check($sformatf("idle%0d_data", d), 64'(rdata[d]), 64'd0);
            check($sformatf("idle%0d_resp", d), 64'(resp[d]), 64'd0);
        end
    endtask

    task automatic check_beat(input logic [31:0] w);
        logic [1:0] cls;
        for (int d = 0; d < 2; d++) begin
            cls = mdl_class(d, w);
            check($sformatf("beat%0d_valid w=%0h", d, w), 64'(rvalid[d]), 64'd1);
            check($sformatf("beat%0d_wait w=%0h", d, w), 64'(waitreq[d]), 64'd1);
            check($sformatf("beat%0d_resp w=%0h", d, w), 64'(resp[d]), 64'(cls));
            if (cls == 2'b11)
                check($sformatf("beat%0d_data w=%0h", d, w), 64'(rdata[d]), 64'd0);
            else if (mdl_known[d][mdl_idx(w)])
                check($sformatf("beat%0d_data w=%0h", d, w), 64'(rdata[d]),
                      64'(mdl_mem[d][mdl_idx(w)]));
        end
    endtask

    // Entered at posedge+1 with the responders idle; leaves them idle at posedge+1.
    task automatic read_burst(input logic [33:0] addr, input logic [4:0] bc, input logic wr_too);
        int n = (bc == 5'd0) ? 1 : int'(bc);
        m_read       = 1'b1;
        m_write      = wr_too;
        m_address    = addr;
        m_burstcount = bc;
        m_writedata  = $urandom;
        m_byteenable = 4'hF;
        @(negedge clk) check_idle();
        @(posedge clk) #1;
        m_read  = 1'b0;
        m_write = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk) check_beat(addr[33:2] + 32'(k));
            @(posedge clk) #1;
        end
    endtask

    // Sends the first 'send' beats of a burst from wd/wbe, with random idle gaps and stray reads.
    task automatic write_burst(input logic [33:0] addr, input logic [4:0] bc, input int send);
        for (int k = 0; k < send; k++) begin
            if (k > 0 && $urandom_range(0, 3) == 0) begin
                m_write = 1'b0;
                m_read  = 1'($urandom_range(0, 1));
                @(negedge clk) check_idle();
                @(posedge clk) #1;
            end
            m_write      = 1'b1;
            m_read       = (k > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_address    = (k > 0) ? {$urandom, 2'b00} : addr;
            m_burstcount = (k > 0) ? 5'($urandom_range(0, 31)) : bc;
            m_writedata  = wd[k];
            m_byteenable = wbe[k];
            @(negedge clk) check_idle();
            @(posedge clk) mdl_write(addr[33:2] + 32'(k), wd[k], wbe[k]);
            #1;
        end
        m_write = 1'b0;
        m_read  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_burstcount = '0;
        #2 check_idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  bc;
        int          n;

        rst_n = 1'b0;
        m_read = 1'b0; m_write = 1'b0; m_address = '0; m_burstcount = '0;
        m_writedata = '0; m_byteenable = '0;
        #12 check_idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Single read of a preloaded word; instance 1 sees it as the error window.
        wd[0] = 32'hDEADBEAF; wbe[0] = 4'hF;
        write_burst(34'h1000, 5'd1, 1);
        read_burst(34'h1000, 5'd1, 1'b0);

        // Four-beat write then four-beat read.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); wbe[k] = 4'hF; end
        write_burst(34'h2000, 5'd4, 4);
        read_burst(34'h2000, 5'd4, 1'b0);

        // Byte lanes 0 and 2 only.
        wd[0] = 32'h11223344; wbe[0] = 4'hF;
        write_burst(34'h3000, 5'd1, 1);
        wd[0] = 32'hAABBCCDD; wbe[0] = 4'b0101;
        write_burst(34'h3000, 5'd1, 1);
        read_burst(34'h3000, 5'd1, 1'b0);

        // Error window then decode error; write past the end must not alias onto word 0.
        wd[0] = 32'h0BADF00D; wbe[0] = 4'hF;
        write_burst(34'h1004, 5'd1, 1);
        read_burst(34'h1000, 5'd2, 1'b0);
        wd[0] = 32'h00C0FFEE; wbe[0] = 4'hF;
        write_burst(34'h0, 5'd1, 1);
        read_burst(34'h8000, 5'd1, 1'b0);
        wd[0] = 32'h55555555; wbe[0] = 4'hF;
        write_burst(34'h8000, 5'd1, 1);
        read_burst(34'h0, 5'd1, 1'b0);

        // End-of-memory crossing and 2^32-word wrap.
        wd[0] = 32'h7777AAAA; wbe[0] = 4'hF;
        write_burst(34'h7FFC, 5'd1, 1);
        read_burst(34'h7FFC, 5'd3, 1'b0);
        read_burst({32'hFFFF_FFFF, 2'b00}, 5'd2, 1'b0);

        // Reset during beat 2 of an eight-beat read.
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; wbe[k] = 4'hF; end
        write_burst(34'h5000, 5'd8, 8);
        m_read = 1'b1; m_address = 34'h5000; m_burstcount = 5'd8;
        @(negedge clk) check_idle();
        @(posedge clk) #1;
        m_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) check_beat(32'h1400 + 32'(k));
            @(posedge clk) #1;
        end
        do_reset();
        read_burst(34'h5008, 5'd1, 1'b0);

        // Aborted write burst keeps the beats already written.
        wd[0] = 32'h01010101; wd[1] = 32'h02020202; wbe[0] = 4'hF; wbe[1] = 4'hF;
        write_burst(34'h4000, 5'd4, 2);
        do_reset();
        read_burst(34'h4000, 5'd2, 1'b0);

        // Read and write together: read wins; then burstcount 0 gives one beat.
        read_burst(34'h2000, 5'd1, 1'b1);
        read_burst(34'h2000, 5'd0, 1'b0);

        // Random bursts around the error window and the top of memory.
        for (int it = 0; it < 40; it++) begin
            w  = ($urandom_range(0, 4) == 0) ? 32'(8185 + $urandom_range(0, 10))
                                             : 32'($urandom_range(1020, 1040));
            bc = 5'($urandom_range(0, 8));
            n  = (bc == 5'd0) ? 1 : int'(bc);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) begin
                    wd[k]  = $urandom;
                    wbe[k] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
                end
                write_burst({w, 2'($urandom_range(0, 3))}, bc, n);
            end else begin
                read_burst({w, 2'($urandom_range(0, 3))}, bc, 1'b0);
            end
        end

        @(negedge clk) check_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
